// File: rtl/wb_sel_pipe.sv
// wb_sel_pipe: writeback-select pipeline stage between MEM and the register file.
//
// Selects one of NUM_SRC packed data sources and one of rt/rd/LINK_REG as the
// destination, then registers the result (1-cycle latency). It also supports
// stall (hold everything) and flush (kill the captured instruction), flags
// out-of-range source selects, detects forwarding hits from the registered
// state and counts retired register writes with a saturating counter.
//
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   stall, flush                 hold all registers / kill the captured instruction
//   in_valid, reg_write_in       incoming instruction valid / writes the register file
//   src_sel, src_data            source index / packed sources (k at [k*DATA_W +: DATA_W])
//   dst_sel, rt, rd              destination select (00 rt, 01 rd, 1x LINK_REG) and fields
//   out_valid, wb_data, wb_addr  registered valid, data and destination
//   wb_we, sel_err               registered write enable / out-of-range select flag
//   fwd_rs, fwd_rt               consumer source registers
//   fwd_rs_hit, fwd_rt_hit       forward wb_data to the consumer operand
//   wr_count                     saturating count of retired register writes
//
// Handshake: out_valid qualifies wb_data/wb_addr/wb_we/sel_err; there is no
// backpressure path, stall freezes the stage for as long as it is held.
module wb_sel_pipe #(
  parameter int DATA_W   = 32,
  parameter int NUM_SRC  = 5,
  parameter int SEL_W    = 3,
  parameter int REG_W    = 5,
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [SEL_W-1:0]          src_sel,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [1:0]                dst_sel,
  input  logic [REG_W-1:0]          rt,
  input  logic [REG_W-1:0]          rd,
  input  logic                      reg_write_in,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         wb_data,
  output logic [REG_W-1:0]          wb_addr,
  output logic                      wb_we,
  output logic                      sel_err,
  input  logic [REG_W-1:0]          fwd_rs,
  input  logic [REG_W-1:0]          fwd_rt,
  output logic                      fwd_rs_hit,
  output logic                      fwd_rt_hit,
  output logic [CNT_W-1:0]          wr_count
);

  // One extra bit so NUM_SRC == 2**SEL_W is representable; the compare is
  // then always true and sel_err can never rise.
  localparam logic [SEL_W:0]   NUM_SRC_W = (SEL_W+1)'(NUM_SRC);
  localparam logic [REG_W-1:0] LINK_ADDR = REG_W'(LINK_REG);

  logic                 w_sel_ok;
  logic [DATA_W-1:0]    w_sel_data;
  logic [REG_W-1:0]     w_addr;
  logic                 w_we;
  logic                 w_err;

  logic                 r_valid;
  logic [DATA_W-1:0]    r_data;
  logic [REG_W-1:0]     r_addr;
  logic                 r_we;
  logic                 r_err;
  logic [CNT_W-1:0]     r_cnt;

  assign w_sel_ok = ({1'b0, src_sel} < NUM_SRC_W);

  // An out-of-range index matches no source, so the data falls back to zero.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_sel == SEL_W'(k)) begin
        w_sel_data = src_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_addr = LINK_ADDR;
    case (dst_sel)
      2'b00:   w_addr = rt;
      2'b01:   w_addr = rd;
      default: w_addr = LINK_ADDR;
    endcase
  end

  // Writes to $0 and writes with a bad source select are suppressed here, so
  // the forwarding compare below needs no separate zero-register check.
  assign w_we  = in_valid & reg_write_in & (w_addr != '0) & w_sel_ok;
  assign w_err = in_valid & ~w_sel_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (!stall) begin
      r_data <= w_sel_data;
      r_addr <= w_addr;
      if (flush) begin
        r_valid <= 1'b0;
        r_we    <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        r_valid <= in_valid;
        r_we    <= w_we;
        r_err   <= w_err;
        if (w_we && !(&r_cnt)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid  = r_valid;
  assign wb_data    = r_data;
  assign wb_addr    = r_addr;
  assign wb_we      = r_we;
  assign sel_err    = r_err;
  assign wr_count   = r_cnt;

  assign fwd_rs_hit = r_valid & r_we & (r_addr == fwd_rs);
  assign fwd_rt_hit = r_valid & r_we & (r_addr == fwd_rt);

endmodule

// File: tb/tb_wb_sel_pipe.sv
// Testbench for wb_sel_pipe. Two instances share one stimulus bus:
//   dut_a: NUM_SRC=5, CNT_W=16 (out-of-range selects possible)
//   dut_b: NUM_SRC=8, CNT_W=2  (full select range, small saturating counter)
// Each step pushes the expected post-edge outputs of both instances into
// exp_q; a monitor pops and compares at every falling edge.
module tb_wb_sel_pipe;

  localparam int W = 116;   // two 58-bit expectation records

  logic         clk = 1'b0;
  logic         rst, stall, flush, in_valid, reg_write_in;
  logic [2:0]   src_sel;
  logic [255:0] src_data;
  logic [1:0]   dst_sel;
  logic [4:0]   rt, rd, fwd_rs, fwd_rt;
  logic [31:0]  src_w [8];

  logic         a_valid, a_we, a_err, a_hrs, a_hrt;
  logic [31:0]  a_data;
  logic [4:0]   a_addr;
  logic [15:0]  a_cnt;
  logic         b_valid, b_we, b_err, b_hrs, b_hrt;
  logic [31:0]  b_data;
  logic [4:0]   b_addr;
  logic [1:0]   b_cnt;

  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  // Reference state per instance, kept as plain values.
  int           m_valid [2];
  int           m_we    [2];
  int           m_err   [2];
  int           m_cnt   [2];
  logic [31:0]  m_data  [2];
  logic [4:0]   m_addr  [2];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  wb_sel_pipe #(.DATA_W(32), .NUM_SRC(5), .SEL_W(3), .REG_W(5), .LINK_REG(31), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .src_sel(src_sel), .src_data(src_data[159:0]), .dst_sel(dst_sel), .rt(rt), .rd(rd),
    .reg_write_in(reg_write_in), .out_valid(a_valid), .wb_data(a_data), .wb_addr(a_addr),
    .wb_we(a_we), .sel_err(a_err), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .fwd_rs_hit(a_hrs), .fwd_rt_hit(a_hrt), .wr_count(a_cnt));

  wb_sel_pipe #(.DATA_W(32), .NUM_SRC(8), .SEL_W(3), .REG_W(5), .LINK_REG(31), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .src_sel(src_sel), .src_data(src_data), .dst_sel(dst_sel), .rt(rt), .rd(rd),
    .reg_write_in(reg_write_in), .out_valid(b_valid), .wb_data(b_data), .wb_addr(b_addr),
    .wb_we(b_we), .sel_err(b_err), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .fwd_rs_hit(b_hrs), .fwd_rt_hit(b_hrt), .wr_count(b_cnt));

  // ---------------- reference model ----------------
  task automatic model_update(input int i, input int num_src, input int cnt_max);
    int          ok, we;
    logic [4:0]  addr;
    if (rst) begin
      m_valid[i] = 0; m_we[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
      m_data[i] = 32'h0; m_addr[i] = 5'h0;
    end else if (!stall) begin
      ok   = (int'(src_sel) < num_src) ? 1 : 0;
      addr = (dst_sel == 2'd0) ? rt : (dst_sel == 2'd1) ? rd : 5'd31;
      we   = (in_valid && reg_write_in && addr != 5'd0 && ok == 1) ? 1 : 0;
      m_data[i] = (ok == 1) ? src_w[src_sel] : 32'h0;
      m_addr[i] = addr;
      if (flush) begin
        m_valid[i] = 0; m_we[i] = 0; m_err[i] = 0;
      end else begin
        m_valid[i] = in_valid ? 1 : 0;
        m_we[i]    = we;
        m_err[i]   = (in_valid && ok == 0) ? 1 : 0;
        if (we == 1 && m_cnt[i] < cnt_max) m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  function automatic logic [57:0] pack_exp(input int i);
    logic hrs, hrt;
    hrs = (m_valid[i] == 1 && m_we[i] == 1 && m_addr[i] == fwd_rs);
    hrt = (m_valid[i] == 1 && m_we[i] == 1 && m_addr[i] == fwd_rt);
    return {m_valid[i][0], m_data[i], m_addr[i], m_we[i][0], m_err[i][0],
            m_cnt[i][15:0], hrs, hrt};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic new_words();
    for (int k = 0; k < 8; k++) src_w[k] = $urandom;
  endtask

  task automatic set_idle();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; reg_write_in = 1'b0;
    src_sel = 3'd0; dst_sel = 2'd0; rt = 5'd0; rd = 5'd0; fwd_rs = 5'd0; fwd_rt = 5'd0;
    new_words();
  endtask

  // Apply the current inputs for one edge; expected values are queued first,
  // then the step returns just after the falling edge so the monitor samples
  // with this step's fwd_rs/fwd_rt still on the bus.
  task automatic step();
    for (int k = 0; k < 8; k++) src_data[k*32 +: 32] = src_w[k];
    model_update(0, 5, 65535);
    model_update(1, 8, 3);
    exp_q.push_back({pack_exp(0), pack_exp(1)});
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d @%0t: got %h expected %h", name, inst, $time, act, exp);
    end
  endtask

  task automatic check_rec(input int inst, input logic [57:0] e, input logic [57:0] a);
    cmp("out_valid",  inst, {31'h0, a[57]},    {31'h0, e[57]});
    cmp("wb_data",    inst, a[56:25],          e[56:25]);
    cmp("wb_addr",    inst, {27'h0, a[24:20]}, {27'h0, e[24:20]});
    cmp("wb_we",      inst, {31'h0, a[19]},    {31'h0, e[19]});
    cmp("sel_err",    inst, {31'h0, a[18]},    {31'h0, e[18]});
    cmp("wr_count",   inst, {16'h0, a[17:2]},  {16'h0, e[17:2]});
    cmp("fwd_rs_hit", inst, {31'h0, a[1]},     {31'h0, e[1]});
    cmp("fwd_rt_hit", inst, {31'h0, a[0]},     {31'h0, e[0]});
  endtask

  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_rec(0, e[115:58], {a_valid, a_data, a_addr, a_we, a_err, a_cnt, a_hrs, a_hrt});
      check_rec(1, e[57:0],   {b_valid, b_data, b_addr, b_we, b_err, 14'h0, b_cnt, b_hrs, b_hrt});
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // Basic capture from source 2 into rd.
    in_valid = 1'b1; src_sel = 3'd2; src_w[2] = 32'hDEADBEEF;
    dst_sel = 2'b01; rd = 5'd8; reg_write_in = 1'b1; fwd_rs = 5'd8;
    step();

    // Link destination with both encodings.
    new_words(); dst_sel = 2'b10; rt = 5'd3; rd = 5'd4; src_sel = 3'd1;
    step();
    new_words(); dst_sel = 2'b11; fwd_rs = 5'd31; fwd_rt = 5'd30;
    step();

    // Out-of-range select on dut_a (in range for dut_b), then back in range.
    new_words(); src_sel = 3'd7; dst_sel = 2'b01; rd = 5'd9; fwd_rs = 5'd9;
    step();
    new_words(); src_sel = 3'd3;
    step();

    // Destination $0 never writes or forwards.
    new_words(); src_sel = 3'd1; dst_sel = 2'b00; rt = 5'd0; fwd_rs = 5'd0; fwd_rt = 5'd0;
    step();

    // Stall wins over flush while inputs churn.
    stall = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      new_words(); in_valid = 1'b1; reg_write_in = 1'b1; dst_sel = 2'b01;
      src_sel = 3'($urandom_range(0, 7)); rd = 5'($urandom_range(1, 31));
      step();
    end
    stall = 1'b0; rd = 5'd5; src_sel = 3'd0;
    step();
    flush = 1'b0;

    // Fresh counters, then five writes saturate dut_b's 2-bit counter.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      new_words(); in_valid = 1'b1; reg_write_in = 1'b1; dst_sel = 2'b01;
      rd = 5'(i + 1); src_sel = 3'(i); fwd_rs = 5'(i + 1); fwd_rt = 5'(i);
      step();
    end
    new_words(); rd = 5'd12; step();
    rst = 1'b1; step(); rst = 1'b0;
    in_valid = 1'b0; step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      new_words();
      rst          = ($urandom_range(0, 49) == 0);
      stall        = ($urandom_range(0, 7) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      reg_write_in = ($urandom_range(0, 3) != 0);
      src_sel      = 3'($urandom_range(0, 7));
      dst_sel      = 2'($urandom_range(0, 3));
      rt           = 5'($urandom_range(0, 7));
      rd           = 5'($urandom_range(0, 7));
      fwd_rs       = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      fwd_rt       = 5'($urandom_range(0, 7));
      step();
    end

    set_idle();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL exp_q_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
